// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI4-Stream pair checker.
// Optional feature: define AXICHK_PAD_CHECK_EN to require zero pad bytes
// (bytes 1..DATA_BYTES-1); this widens the error-flag vector to 4 bits.
package axis_chk_pkg;

    typedef enum logic {
        EXP_IDX  = 1'b0,
        EXP_MARK = 1'b1
    } chk_state_e;

    localparam int unsigned ERR_SEQ    = 0;
    localparam int unsigned ERR_MARKER = 1;
    localparam int unsigned ERR_LAST   = 2;
`ifdef AXICHK_PAD_CHECK_EN
    localparam int unsigned ERR_PAD    = 3;
    localparam int unsigned ERR_W      = 4;
`else
    localparam int unsigned ERR_W      = 3;
`endif

    localparam logic [7:0] MARKER_DEFAULT = 8'h9E;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axis_pair_checker_if.sv
// AXI4-Stream bundle used on both sides of the pair checker.
interface axis_pair_checker_if #(
    parameter int unsigned DATA_BYTES = 64
) ();
    logic [8*DATA_BYTES-1:0] tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: registered ready (low when full), one cycle from
// accept to output valid, strict in-order delivery.
module axis_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic [1:0]   count_next;
    logic         ready_q;
    logic         push;
    logic         pop;

    assign push    = s_valid & ready_q;
    assign pop     = (count != 2'd0) & m_ready;
    assign s_ready = ready_q;
    assign m_valid = (count != 2'd0);
    assign m_data  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count + 2'(push) - 2'(pop);
    end

    // Storage, pointers, occupancy and the registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem     <= '{default: '0};
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= s_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
        end
    end

endmodule

// File: rtl/axis_pair_checker.sv
// In-line AXI4-Stream checker for (index beat, marker beat) pairs.
// Forwards every beat unchanged through a skid buffer and records sequence,
// marker and TLAST-placement errors as sticky flags plus counters.
// Optional feature: AXICHK_PAD_CHECK_EN adds a nonzero-pad-byte check.
module axis_pair_checker
    import axis_chk_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 64,
    parameter int unsigned IDX_W      = 8,
    parameter logic [7:0]  MARKER     = MARKER_DEFAULT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_pair_checker_if.slave   s_axis,
    axis_pair_checker_if.master  m_axis,
    input  logic                 clear_stats,
    output logic [ERR_W-1:0]     err_flags,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     frame_count
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned PW = DW + 1;

    logic             in_ready;
    logic [PW-1:0]    out_payload;
    logic             accept;
    chk_state_e       state_q;
    chk_state_e       state_d;
    logic [IDX_W-1:0] exp_idx_q;
    logic [IDX_W-1:0] exp_idx_d;
    logic [IDX_W-1:0] beat_idx;
    logic [ERR_W-1:0] beat_err;
    logic             frame_done;

    assign s_axis.tready = in_ready;
    assign accept        = s_axis.tvalid & in_ready;
    assign beat_idx      = s_axis.tdata[IDX_W-1:0];

    axis_skid_buf #(
        .W (PW)
    ) u_skid (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (s_axis.tvalid),
        .s_ready (in_ready),
        .s_data  ({s_axis.tlast, s_axis.tdata}),
        .m_valid (m_axis.tvalid),
        .m_ready (m_axis.tready),
        .m_data  (out_payload)
    );

    assign m_axis.tlast = out_payload[DW];
    assign m_axis.tdata = out_payload[DW-1:0];

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= EXP_IDX;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a TLAST on an index beat keeps us expecting an index.
    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                EXP_IDX:  state_d = s_axis.tlast ? EXP_IDX : EXP_MARK;
                EXP_MARK: state_d = EXP_IDX;
                default:  state_d = EXP_IDX;
            endcase
        end
    end

    // FSM outputs: per-beat error bits, next expected index, frame completion.
    always_comb begin
        beat_err   = '0;
        exp_idx_d  = exp_idx_q;
        frame_done = 1'b0;
        if (accept) begin
            case (state_q)
                EXP_IDX: begin
                    if (beat_idx != exp_idx_q) begin
                        beat_err[ERR_SEQ] = 1'b1;
                        exp_idx_d         = beat_idx + IDX_W'(1);
                    end else begin
                        exp_idx_d = exp_idx_q + IDX_W'(1);
                    end
                    if (s_axis.tlast) begin
                        beat_err[ERR_LAST] = 1'b1;
                        exp_idx_d          = '0;
                    end
                end
                EXP_MARK: begin
                    if (s_axis.tdata[7:0] != MARKER) begin
                        beat_err[ERR_MARKER] = 1'b1;
                    end
                    if (s_axis.tlast) begin
                        frame_done = 1'b1;
                        exp_idx_d  = '0;
                    end
                end
                default: ;
            endcase
`ifdef AXICHK_PAD_CHECK_EN
            if (s_axis.tdata[DW-1:8] != '0) begin
                beat_err[ERR_PAD] = 1'b1;
            end
`endif
        end
    end

    // Expected-index register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            exp_idx_q <= '0;
        end else begin
            exp_idx_q <= exp_idx_d;
        end
    end

    // Sticky flags and counters; clear_stats wins over same-cycle events.
    always_ff @(posedge aclk) begin
        if (areset || clear_stats) begin
            err_flags   <= '0;
            err_count   <= '0;
            frame_count <= '0;
        end else begin
            err_flags <= err_flags | beat_err;
            if (|beat_err) begin
                err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
            end
            if (frame_done) begin
                frame_count <= frame_count + CNT_W'(1);
            end
        end
    end

endmodule
